// File: rtl/subleq_sequencer_if.sv
// CPU-side bus between the SUBLEQ sequencer (master) and the memory-mapped I/O decoder (slave).
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

interface subleq_sequencer_if #(parameter int W = `WORD_SIZE);
    logic [W-1:0] addr;
    logic         load;
    logic [W-1:0] data_out;
    logic [W-1:0] data_in;
    logic         halt;

    modport master (output addr, output load, output data_out, input data_in, input halt);
    modport slave  (input addr, input load, input data_out, output data_in, output halt);
endinterface

// File: rtl/subleq_sequencer.sv
// SUBLEQ control sequencer: fetch A/B/C, read operands, write B-A back, branch on result <= 0.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

module subleq_sequencer #(
    parameter int WORD_SIZE = `WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    subleq_sequencer_if.master   bus,
    output logic                 halted,
    output logic [WORD_SIZE-1:0] pc
);

    typedef enum logic [2:0] {
        S_FA   = 3'd0,
        S_FB   = 3'd1,
        S_FC   = 3'd2,
        S_RA   = 3'd3,
        S_RB   = 3'd4,
        S_WR   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    localparam logic [WORD_SIZE-1:0] ZERO = {WORD_SIZE{1'b0}};

    state_t               r_state;
    state_t               w_next;
    state_t               w_seq;
    logic [WORD_SIZE-1:0] r_pc;
    logic [WORD_SIZE-1:0] r_a;
    logic [WORD_SIZE-1:0] r_b;
    logic [WORD_SIZE-1:0] r_c;
    logic [WORD_SIZE-1:0] r_va;
    logic [WORD_SIZE-1:0] r_vb;
    logic                 r_halted;

    logic [WORD_SIZE-1:0] w_pc1;
    logic [WORD_SIZE-1:0] w_pc2;
    logic [WORD_SIZE-1:0] w_pc3;
    logic [WORD_SIZE-1:0] w_diff;
    logic                 w_le0;
    logic                 w_run;
    logic                 w_adv;
    logic [WORD_SIZE-1:0] w_addr;
    logic                 w_load;
    logic [WORD_SIZE-1:0] w_dout;

    assign w_pc1  = r_pc + WORD_SIZE'(1);
    assign w_pc2  = r_pc + WORD_SIZE'(2);
    assign w_pc3  = r_pc + WORD_SIZE'(3);
    assign w_diff = r_vb - r_va;
    assign w_le0  = (w_diff == ZERO) || w_diff[WORD_SIZE-1];
    assign w_run  = enable && (r_state != S_HALT);
    // Registers only advance when running and the decoder is not signalling halt.
    assign w_adv  = w_run && !bus.halt;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FA;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and bus drive; a stalled or halted core parks the bus at addr 0, read.
    always_comb begin
        w_next = r_state;
        w_seq  = r_state;
        w_addr = ZERO;
        w_load = 1'b1;
        w_dout = ZERO;
        if (w_run) begin
            case (r_state)
                S_FA: begin w_addr = r_pc;  w_seq = S_FB; end
                S_FB: begin w_addr = w_pc1; w_seq = S_FC; end
                S_FC: begin w_addr = w_pc2; w_seq = S_RA; end
                S_RA: begin w_addr = r_a;   w_seq = S_RB; end
                S_RB: begin w_addr = r_b;   w_seq = S_WR; end
                S_WR: begin
                    w_addr = r_b;
                    w_load = 1'b0;
                    w_dout = w_diff;
                    w_seq  = S_FA;
                end
                default: w_seq = S_HALT;
            endcase
            if (bus.halt) begin
                w_next = S_HALT;
            end else begin
                w_next = w_seq;
            end
        end else begin
            w_next = r_state;
        end
    end

    // Architectural state: operand latches, pc and the sticky halted flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= ZERO;
            r_a      <= ZERO;
            r_b      <= ZERO;
            r_c      <= ZERO;
            r_va     <= ZERO;
            r_vb     <= ZERO;
            r_halted <= 1'b0;
        end else begin
            r_halted <= r_halted || (w_run && bus.halt);
            if (w_adv) begin
                case (r_state)
                    S_FA:    r_a  <= bus.data_in;
                    S_FB:    r_b  <= bus.data_in;
                    S_FC:    r_c  <= bus.data_in;
                    S_RA:    r_va <= bus.data_in;
                    S_RB:    r_vb <= bus.data_in;
                    S_WR:    r_pc <= w_le0 ? r_c : w_pc3;
                    default: r_pc <= r_pc;
                endcase
            end
        end
    end

    assign bus.addr     = w_addr;
    assign bus.load     = w_load;
    assign bus.data_out = w_dout;
    assign halted       = r_halted;
    assign pc           = r_pc;

endmodule

// File: tb/tb_subleq_sequencer.sv
// Directed bench: sequencer plus a behavioural 256-word memory and I/O decoder (W=8).
module tb_subleq_sequencer;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       enable = 1'b0;
    logic       io_en  = 1'b1;
    logic       eof    = 1'b0;
    logic [7:0] io_in  = 8'h00;
    logic [7:0] io_out;
    logic [7:0] mem [0:255];
    logic       halted;
    logic [7:0] pc;
    int         n_vec = 0;
    int         n_err = 0;
    int         n_rd;
    int         n_wo;
    int         n_wr;
    logic [7:0] last_wa;

    subleq_sequencer_if #(.W(8)) bus();

    subleq_sequencer #(.WORD_SIZE(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .bus    (bus),
        .halted (halted),
        .pc     (pc)
    );

    always #5 clk = ~clk;

    // Decoder: 0xFD out, 0xFE in (halts on eof), 0xFF halt; io_en=0 makes it plain memory.
    always_comb begin
        bus.data_in = mem[bus.addr];
        bus.halt    = 1'b0;
        if (io_en && bus.load) begin
            if (bus.addr == 8'hFE) begin
                bus.data_in = eof ? 8'h00 : io_in;
            end else if (bus.addr == 8'hFD || bus.addr == 8'hFF) begin
                bus.data_in = 8'h00;
            end
            bus.halt = (bus.addr == 8'hFF) || (bus.addr == 8'hFE && eof);
        end
    end

    always @(posedge clk) begin
        if (!bus.load && (!io_en || bus.addr < 8'hFD)) mem[bus.addr] <= bus.data_out;
        if (rst) begin
            n_rd <= 0;
            n_wo <= 0;
            n_wr <= 0;
        end else begin
            if (!bus.load) begin
                n_wr    <= n_wr + 1;
                last_wa <= bus.addr;
                if (io_en && bus.addr == 8'hFD) begin
                    n_wo   <= n_wo + 1;
                    io_out <= bus.data_out;
                end
            end else if (io_en && bus.addr == 8'hFE && !eof) begin
                n_rd <= n_rd + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic begin_test();
        rst    = 1'b1;
        enable = 1'b0;
        io_en  = 1'b1;
        eof    = 1'b0;
        @(posedge clk);
        #2;
        for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    endtask

    task automatic go();
        @(posedge clk);
        #2;
        rst    = 1'b0;
        enable = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset state and basic subtract without branch.
        begin_test();
        mem[0] <= 8'd10; mem[1] <= 8'd11; mem[2] <= 8'd3;
        mem[10] <= 8'd2; mem[11] <= 8'd5;
        #1;
        chk("rst_addr", 32'(bus.addr), 32'h0);
        chk("rst_load", 32'(bus.load), 32'h1);
        chk("rst_dout", 32'(bus.data_out), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_pc", 32'(pc), 32'h0);
        go();
        #1;
        chk("fa_addr", 32'(bus.addr), 32'h0);
        step(5);
        chk("wr_load", 32'(bus.load), 32'h0);
        chk("wr_addr", 32'(bus.addr), 32'd11);
        chk("wr_dout", 32'(bus.data_out), 32'd3);
        chk("wr_pc_old", 32'(pc), 32'h0);
        step(1);
        chk("basic_mem", 32'(mem[11]), 32'd3);
        chk("basic_pc", 32'(pc), 32'd3);
        chk("basic_nwr", 32'(n_wr), 32'd1);
        chk("basic_wa", 32'(last_wa), 32'd11);
        chk("basic_next", 32'(bus.addr), 32'd3);

        // Branch on zero, then on negative.
        begin_test();
        mem[0] <= 8'd10; mem[1] <= 8'd11; mem[2] <= 8'd40;
        mem[10] <= 8'd5; mem[11] <= 8'd5;
        go();
        step(6);
        chk("bz_mem", 32'(mem[11]), 32'h0);
        chk("bz_pc", 32'(pc), 32'd40);
        begin_test();
        mem[0] <= 8'd10; mem[1] <= 8'd11; mem[2] <= 8'd40;
        mem[10] <= 8'd7; mem[11] <= 8'd5;
        go();
        step(6);
        chk("bn_mem", 32'(mem[11]), 32'hFE);
        chk("bn_pc", 32'(pc), 32'd40);

        // I/O read then I/O write.
        begin_test();
        io_in = 8'd9;
        mem[0] <= 8'hFE; mem[1] <= 8'd20; mem[2] <= 8'd3; mem[20] <= 8'd9;
        go();
        step(6);
        chk("ior_pulses", 32'(n_rd), 32'd1);
        chk("ior_mem", 32'(mem[20]), 32'h0);
        chk("ior_pc", 32'(pc), 32'd3);
        begin_test();
        mem[0] <= 8'd30; mem[1] <= 8'hFD; mem[2] <= 8'd6; mem[30] <= 8'hFC;
        go();
        step(6);
        chk("iow_pulses", 32'(n_wo), 32'd1);
        chk("iow_data", 32'(io_out), 32'd4);
        chk("iow_pc", 32'(pc), 32'd3);

        // Halt via read of 0xFF, then via eof on a 0xFE read.
        begin_test();
        mem[0] <= 8'hFF;
        go();
        step(3);
        chk("h_seen", 32'(bus.halt), 32'h1);
        chk("h_pre", 32'(halted), 32'h0);
        step(1);
        chk("h_halted", 32'(halted), 32'h1);
        chk("h_addr", 32'(bus.addr), 32'h0);
        chk("h_load", 32'(bus.load), 32'h1);
        chk("h_pc", 32'(pc), 32'h0);
        step(3);
        chk("h_sticky", 32'(halted), 32'h1);
        chk("h_nwr", 32'(n_wr), 32'h0);
        begin_test();
        #1;
        chk("h_rst_clr", 32'(halted), 32'h0);
        mem[0] <= 8'hFE; mem[1] <= 8'd20; mem[2] <= 8'd3;
        go();
        eof = 1'b1;
        step(4);
        chk("eof_halted", 32'(halted), 32'h1);
        chk("eof_nrd", 32'(n_rd), 32'h0);
        chk("eof_pc", 32'(pc), 32'h0);

        // Stall during an I/O read.
        begin_test();
        io_in = 8'd9;
        mem[0] <= 8'hFE; mem[1] <= 8'd20; mem[2] <= 8'd3; mem[20] <= 8'd9;
        go();
        step(3);
        chk("st_ra_addr", 32'(bus.addr), 32'hFE);
        enable = 1'b0;
        #1;
        chk("st_addr", 32'(bus.addr), 32'h0);
        chk("st_load", 32'(bus.load), 32'h1);
        step(5);
        chk("st_nrd", 32'(n_rd), 32'h0);
        enable = 1'b1;
        #1;
        chk("st_reissue", 32'(bus.addr), 32'hFE);
        step(3);
        chk("st_nrd_after", 32'(n_rd), 32'd1);
        chk("st_mem", 32'(mem[20]), 32'h0);
        chk("st_pc", 32'(pc), 32'd3);

        // Reset asserted in the middle of WR.
        begin_test();
        mem[0] <= 8'd10; mem[1] <= 8'd11; mem[2] <= 8'd3;
        mem[10] <= 8'd2; mem[11] <= 8'd5;
        go();
        step(5);
        rst = 1'b1;
        #1;
        chk("rw_addr", 32'(bus.addr), 32'h0);
        chk("rw_load", 32'(bus.load), 32'h1);
        chk("rw_dout", 32'(bus.data_out), 32'h0);
        step(1);
        chk("rw_nowrite", 32'(mem[11]), 32'd5);
        rst = 1'b0;
        step(6);
        chk("rw_restart_pc", 32'(pc), 32'd3);
        chk("rw_restart_mem", 32'(mem[11]), 32'd3);

        // Address wrap with the I/O decode disabled.
        begin_test();
        io_en = 1'b0;
        mem[0] <= 8'd10; mem[1] <= 8'd10; mem[2] <= 8'hFE;
        mem[8'hFE] <= 8'd10; mem[8'hFF] <= 8'd10;
        go();
        step(6);
        chk("wrap_pc", 32'(pc), 32'hFE);
        chk("wrap_fa", 32'(bus.addr), 32'hFE);
        step(1);
        chk("wrap_fb", 32'(bus.addr), 32'hFF);
        step(1);
        chk("wrap_fc", 32'(bus.addr), 32'h00);
        begin_test();
        io_en = 1'b0;
        mem[0] <= 8'd10; mem[1] <= 8'd10; mem[2] <= 8'hFD;
        mem[8'hFD] <= 8'd11; mem[8'hFE] <= 8'd12; mem[8'hFF] <= 8'd0;
        mem[11] <= 8'd1; mem[12] <= 8'd5;
        go();
        step(6);
        chk("wrap3_pc0", 32'(pc), 32'hFD);
        step(6);
        chk("wrap3_pc", 32'(pc), 32'h00);
        chk("wrap3_mem", 32'(mem[12]), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/subleq_sequencer.md
# subleq_sequencer

Control sequencer for the SUBLEQ core. It walks each instruction through fetch, operand read, subtract, write-back and branch. It drives the CPU-side address, load and data bus of the memory-mapped I/O decoder and reacts to that decoder's halt indication. It holds all architectural state: the program counter plus per-instruction operand and value registers.

## Interface
Parameters:
- WORD_SIZE, default `WORD_SIZE, is the data and address width. Addresses 2^W-3, 2^W-2 and 2^W-1 are the I/O write, I/O read and halt locations.

Ports:
- clk, input, 1 bit: the single clock; all state changes on its rising edge.
- rst, input, 1 bit: asynchronous, active-high reset.
- enable, input, 1 bit: run permission. When low, the sequencer stalls and holds all state.
- addr, output, W bits: memory/I/O address, feeding the decoder's addr.
- load, output, 1 bit: 1 means read cycle, 0 means write cycle. The write takes effect at the clock edge ending the cycle.
- data_out, output, W bits: write data.
- data_in, input, W bits: read data. It is combinational and valid in the same cycle as addr with load=1.
- halt, input, 1 bit: the decoder's halt. It is combinational from addr and the I/O eof.
- halted, output, 1 bit: the core has stopped.
- pc, output, W bits: the current program counter, for debug.

## Operation
States and their bus activity:
- FA: addr=pc, load=1. Latch A ← data_in.
- FB: addr=pc+1, load=1. Latch B ← data_in.
- FC: addr=pc+2, load=1. Latch C ← data_in.
- RA: addr=A, load=1. Latch VA ← data_in.
- RB: addr=B, load=1. Latch VB ← data_in.
- WR: addr=B, load=0, data_out=VB−VA.
- HALT: terminal state, left only by reset.

Transitions:
- FA → FB → FC → RA → RB → WR → FA. One state per enabled cycle.
- At the end of WR, pc ← C when (VB−VA) ≤ 0, otherwise pc ← pc+3. "≤ 0" means the result is zero or its MSB is 1 (two's complement).
- Arithmetic: subtraction and pc+1, pc+2, pc+3 are all modulo 2^W, so an instruction at 2^W−2 fetches B from 2^W−1 and C from 0.

Halt:
- If halt=1 at a clock edge while enabled in any non-HALT state, the next state is HALT. A, B, C, VA, VB and pc keep their current values.
- If halt rises during WR, the write cycle still occurs. load is already 0 and the decoder suppresses memory writes to I/O space. pc is not updated.
- halt=1 during FA (pc = 2^W−1) halts before the instruction starts.

Stall:
- enable=0 in any non-HALT state freezes the state and all registers.
- While stalled: addr=0, load=1, data_out=0. This keeps a held I/O-read address from consuming input repeatedly.
- On the next enabled cycle the frozen state reissues its access.

Outputs when not in a bus cycle:
- In HALT and during reset: addr=0, load=1, data_out=0, halted=1 (HALT only).
- data_out is 0 in every state except WR.

## Timing
- Reset values (asynchronous): state=FA, pc=0; A, B, C, VA, VB = 0; halted=0. Outputs while rst=1: addr=0, load=1, data_out=0.
- Release of rst gives FA at pc=0 on the first enabled edge.
- Each instruction takes exactly 6 enabled cycles, with exactly one load=0 cycle (WR) per instruction.
- Reads: data_in is sampled at the same edge that ends the read cycle. Memory read latency is zero.
- halted asserts in the cycle after the edge that samples halt=1. It stays high until rst.
- pc output reflects the registered pc, updated at the edge ending WR.
- Each I/O read or I/O write is presented for exactly one enabled cycle, so the decoder sees exactly one in_read or out_write pulse per access.

## Test plan
All scenarios use W=8 with a behavioural memory and the decoder attached.
- Basic subtract, no branch: mem[0..2]={10,11,3}, mem[10]=2, mem[11]=5 → after 6 cycles mem[11]=3 and pc=3. Exactly one load=0 cycle, at addr 11.
- Branch taken: mem[0..2]={10,11,40}, mem[10]=5, mem[11]=5 → mem[11]=0 and pc=40. Negative result with mem[10]=7 → mem[11]=0xFE and pc=40.
- I/O: instruction {0xFE, 20, 3} with io_in=9 and mem[20]=9 → exactly one in_read pulse, mem[20]=0, branch taken. Instruction {30, 0xFD, 6} with mem[30]=0xFC (−4) → one out_write pulse with io_out=4.
- Halt: instruction {0xFF, 0, 0} → halt seen in RA, halted=1 from the next cycle, addr=0 and load=1 thereafter, pc unchanged. eof=1 during a read of 0xFE → HALT.
- Stall and reset: enable=0 held for 5 cycles during RA with A=0xFE → no in_read while stalled and one in_read after release. rst asserted mid-WR → outputs reset immediately, no write occurs, and execution restarts at pc=0.
- Wrap: instruction at pc=0xFE with mem[0xFF] read blocked → verify fetch addresses 0xFE, 0xFF, 0x00. pc+3 from 0xFD yields 0x00.
